cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  32-bit single-bus CPU datapath: register file R0-R15, HI, LO, PC, MDR, MAR, IR, INPORT, Y and a 64-bit Z.
//  A 32:5 encoder turns the one-hot *out strobes into a select code, and a bus mux drives busMuxOut.
//  A minimal ALU supports AND and PC increment.
//  An external control unit or testbench sequences the *in/*out strobes cycle by cycle.
// PARAMETERS
//  WIDTH  32  data/bus width (Z is 2*WIDTH)
// PORTS
//  Clock              input   1   rising-edge clock
//  Resetn             input   1   synchronous active-low reset
//  R0in..R15in        input   1ea load Rn from bus
//  HIin, LOin, PCin   input   1ea load HI / LO / PC from bus
//  MDRin, INPORTin    input   1ea load MDR (from MDR mux) / INPORT (from bus)
//  Zin, Yin           input   1ea load Z (ALU result) / Y (from bus)
//  MARin, IRin        input   1ea load MAR / IR from bus
//  AND                input   1   ALU op select: Z = Y & bus
//  R0out..R15out      input   1ea drive Rn onto bus
//  HIout, LOout       input   1ea drive HI / LO onto bus
//  ZHIout, ZLOout     input   1ea drive Z[63:32] / Z[31:0] onto bus
//  Zout               input   1   alias of ZLOout
//  PCout, MDRout      input   1ea drive PC / MDR onto bus
//  INPORTout, Yout    input   1ea drive INPORT / Y onto bus
//  Read               input   1   MDR mux select: 1 = Mdatain, 0 = bus
//  IncPC              input   1   ALU op select: Z = bus + 1
//  Mdatain            input   32  memory read data
//  busMuxOut          output  32  current bus value
//  encoderOut         output  5   bus select code
//  BusMuxInR0..R15    output  32ea register contents
//  BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInY
//                     output  32ea contents of the named register
// BEHAVIOUR
//  - Reset: on a posedge Clock with Resetn=0, every register (R0-R15, HI, LO, PC, MDR, MAR, IR, INPORT, Y, Z) clears to 0.
//    Reset overrides all *in strobes.
//  - Loads: each register updates on posedge Clock when its *in is 1, otherwise it holds.
//    R0 is an ordinary register (not hardwired to zero).
//  - Encoder codes: R0-R15 = 0-15, HI = 16, LO = 17, ZHI = 18, ZLO (or Zout) = 19, PC = 20, MDR = 21,
//    INPORT = 22, Y = 23.
//  - No *out strobe asserted: code 31, bus = 0.
//  - Multiple *out strobes asserted: the highest code wins.
//  - Bus mux: combinational, busMuxOut = source[encoderOut]. Zero latency from strobe to bus.
//  - MDR input = Read ? Mdatain : busMuxOut.
//  - ALU (combinational, captured in Z on Zin):
//      IncPC=1            -> Z = {32'b0, bus + 1}, 32-bit wrap (0xFFFFFFFF + 1 = 0).
//      else AND=1         -> Z = {32'b0, Y & bus}.
//      else (no op)       -> Z = {32'b0, bus} (pass-through).
//    IncPC has priority over AND.
//  - Same-cycle loads: a register both driving and loading the bus (e.g. PCout with PCin) reads its old value
//    and captures on the edge with no combinational loop.
//  - Strobes are level-sensitive and sampled only at posedge Clock.
//  - MAR and IR are internal (no BusMuxIn output).
// STRUCTURE
//  - Shared package: encoder code localparams (SEL_R0..SEL_Y, SEL_NONE = 31) and WIDTH.
//  - One sub-module: reg32 (Clock, Resetn, en, d, q), instantiated for every 32-bit register.
//    Z is built from two reg32 instances sharing Zin.
//  - Encoder, bus mux, MDR mux and ALU are inline combinational logic.
// TESTING
//  1. Reset: Resetn=0 for 1 clock -> all BusMuxIn* = 0, encoderOut = 31, busMuxOut = 0.
//  2. Register load: Mdatain = 0x00000012, Read=1, MDRin=1 for 1 clock; then MDRout=1, R1in=1 for 1 clock
//     -> BusMuxInR1 = 0x12.
//  3. Fetch: PC = 0; (PCout, MARin, IncPC, Zin) -> Z = 1; (ZLOout, PCin, Read, MDRin, Mdatain = 0x88918000)
//     -> PC = 1, MDR = 0x88918000; (MDRout, IRin) -> busMuxOut = 0x88918000 and IR loaded.
//  4. AND: R2 = 0x0F0F0F0F, R3 = 0x000000FF; (R2out, Yin), then (R3out, AND, Zin), then (ZLOout, R0in)
//     -> R0 = 0x0000000F, BusMuxInZhi = 0.
//  5. Priority and wrap: R5out and R9out together -> encoderOut = 9. PC = 0xFFFFFFFF with IncPC, Zin
//     -> Zlo = 0. IncPC and AND together -> the increment is used.
//  6. Mid-sequence reset: assert Resetn=0 between the Zin and ZLOout steps -> Z = 0 and R0 stays 0.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus datapath: bus width and the encoder select codes.
package cpu_datapath_pkg;
  localparam int WIDTH = 32;

  localparam logic [4:0] SEL_R0     = 5'd0;
  localparam logic [4:0] SEL_HI     = 5'd16;
  localparam logic [4:0] SEL_LO     = 5'd17;
  localparam logic [4:0] SEL_ZHI    = 5'd18;
  localparam logic [4:0] SEL_ZLO    = 5'd19;
  localparam logic [4:0] SEL_PC     = 5'd20;
  localparam logic [4:0] SEL_MDR    = 5'd21;
  localparam logic [4:0] SEL_INPORT = 5'd22;
  localparam logic [4:0] SEL_Y      = 5'd23;
  localparam logic [4:0] SEL_NONE   = 5'd31;
endpackage

// File: rtl/cpu_datapath_reg32.sv
// Generic bus register: synchronous active-low clear, load on en, otherwise hold.
module reg32
  import cpu_datapath_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge Clock) begin
    if (!Resetn)  q <= '0;
    else if (en)  q <= d;
  end
endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file plus special registers around one combinational bus mux.
// Bus, encoder and ALU are zero-latency; every register captures on the next rising Clock.
module cpu_datapath
  import cpu_datapath_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             HIin, LOin, PCin, MDRin, INPORTin, Zin, Yin, MARin, IRin,
  input  logic             AND,
  input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout, LOout, ZHIout, ZLOout, Zout, PCout, MDRout, INPORTout, Yout,
  input  logic             Read,
  input  logic             IncPC,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] busMuxOut,
  output logic [4:0]       encoderOut,
  output logic [WIDTH-1:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
  output logic [WIDTH-1:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
  output logic [WIDTH-1:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
  output logic [WIDTH-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [WIDTH-1:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
  output logic [WIDTH-1:0] BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInY
);
  logic [15:0]      rin, rout;
  logic [23:0]      out_vec;
  logic [4:0]       sel;
  logic [WIDTH-1:0] bus, alu, mdr_d;
  logic [WIDTH-1:0] r_q [16];
  logic [WIDTH-1:0] src [32];
  logic [WIDTH-1:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, inport_q, y_q, mar_q, ir_q;
  logic             unused_internal;

  assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign out_vec = {Yout, INPORTout, MDRout, PCout, ZLOout | Zout, ZHIout, LOout, HIout, rout};

  // Ascending scan so the highest asserted code overrides lower ones.
  always_comb begin
    sel = SEL_NONE;
    for (int i = 0; i < 24; i++) begin
      if (out_vec[i]) sel = 5'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) src[i] = '0;
    for (int i = 0; i < 16; i++) src[i] = r_q[i];
    src[SEL_HI]     = hi_q;
    src[SEL_LO]     = lo_q;
    src[SEL_ZHI]    = zhi_q;
    src[SEL_ZLO]    = zlo_q;
    src[SEL_PC]     = pc_q;
    src[SEL_MDR]    = mdr_q;
    src[SEL_INPORT] = inport_q;
    src[SEL_Y]      = y_q;
    bus             = src[sel];
  end

  always_comb begin
    alu = bus;
    if (IncPC)    alu = bus + WIDTH'(1);
    else if (AND) alu = y_q & bus;
  end

  assign mdr_d = Read ? Mdatain : bus;

  for (genvar g = 0; g < 16; g++) begin : g_rf
    reg32 u_r (.Clock(Clock), .Resetn(Resetn), .en(rin[g]), .d(bus), .q(r_q[g]));
  end

  reg32 u_hi     (.Clock(Clock), .Resetn(Resetn), .en(HIin),     .d(bus),   .q(hi_q));
  reg32 u_lo     (.Clock(Clock), .Resetn(Resetn), .en(LOin),     .d(bus),   .q(lo_q));
  reg32 u_zhi    (.Clock(Clock), .Resetn(Resetn), .en(Zin),      .d('0),    .q(zhi_q));
  reg32 u_zlo    (.Clock(Clock), .Resetn(Resetn), .en(Zin),      .d(alu),   .q(zlo_q));
  reg32 u_pc     (.Clock(Clock), .Resetn(Resetn), .en(PCin),     .d(bus),   .q(pc_q));
  reg32 u_mdr    (.Clock(Clock), .Resetn(Resetn), .en(MDRin),    .d(mdr_d), .q(mdr_q));
  reg32 u_inport (.Clock(Clock), .Resetn(Resetn), .en(INPORTin), .d(bus),   .q(inport_q));
  reg32 u_y      (.Clock(Clock), .Resetn(Resetn), .en(Yin),      .d(bus),   .q(y_q));
  reg32 u_mar    (.Clock(Clock), .Resetn(Resetn), .en(MARin),    .d(bus),   .q(mar_q));
  reg32 u_ir     (.Clock(Clock), .Resetn(Resetn), .en(IRin),     .d(bus),   .q(ir_q));

  // MAR and IR feed the memory/control side, which lives outside this block.
  assign unused_internal = ^{mar_q, ir_q};

  assign busMuxOut  = bus;
  assign encoderOut = sel;
  assign BusMuxInR0  = r_q[0];  assign BusMuxInR1  = r_q[1];
  assign BusMuxInR2  = r_q[2];  assign BusMuxInR3  = r_q[3];
  assign BusMuxInR4  = r_q[4];  assign BusMuxInR5  = r_q[5];
  assign BusMuxInR6  = r_q[6];  assign BusMuxInR7  = r_q[7];
  assign BusMuxInR8  = r_q[8];  assign BusMuxInR9  = r_q[9];
  assign BusMuxInR10 = r_q[10]; assign BusMuxInR11 = r_q[11];
  assign BusMuxInR12 = r_q[12]; assign BusMuxInR13 = r_q[13];
  assign BusMuxInR14 = r_q[14]; assign BusMuxInR15 = r_q[15];
  assign BusMuxInHI     = hi_q;
  assign BusMuxInLO     = lo_q;
  assign BusMuxInZhi    = zhi_q;
  assign BusMuxInZlo    = zlo_q;
  assign BusMuxInPC     = pc_q;
  assign BusMuxInMDR    = mdr_q;
  assign BusMuxInInport = inport_q;
  assign BusMuxInY      = y_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath with a per-cycle reference model of the visible registers.
module tb_cpu_datapath;
  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] rin, rout;
  logic        HIin, LOin, PCin, MDRin, INPORTin, Zin, Yin, MARin, IRin, AND_op;
  logic        HIout, LOout, ZHIout, ZLOout, Zout, PCout, MDRout, INPORTout, Yout;
  logic        Read, IncPC;
  logic [31:0] Mdatain;
  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
  logic [31:0] bmr [16];
  logic [31:0] bm_hi, bm_lo, bm_zhi, bm_zlo, bm_pc, bm_mdr, bm_inport, bm_y;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state indexed by bus code: 0-15 Rn, 16 HI, 17 LO, 18 Zhi, 19 Zlo, 20 PC, 21 MDR, 22 INPORT, 23 Y.
  logic [31:0] m  [24];
  logic [31:0] nm [24];
  logic [31:0] mb, ma;

  always #5 Clock = ~Clock;

  cpu_datapath dut (
    .Clock(Clock), .Resetn(Resetn),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .INPORTin(INPORTin),
    .Zin(Zin), .Yin(Yin), .MARin(MARin), .IRin(IRin), .AND(AND_op),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .Zout(Zout),
    .PCout(PCout), .MDRout(MDRout), .INPORTout(INPORTout), .Yout(Yout),
    .Read(Read), .IncPC(IncPC), .Mdatain(Mdatain),
    .busMuxOut(busMuxOut), .encoderOut(encoderOut),
    .BusMuxInR0(bmr[0]), .BusMuxInR1(bmr[1]), .BusMuxInR2(bmr[2]), .BusMuxInR3(bmr[3]),
    .BusMuxInR4(bmr[4]), .BusMuxInR5(bmr[5]), .BusMuxInR6(bmr[6]), .BusMuxInR7(bmr[7]),
    .BusMuxInR8(bmr[8]), .BusMuxInR9(bmr[9]), .BusMuxInR10(bmr[10]), .BusMuxInR11(bmr[11]),
    .BusMuxInR12(bmr[12]), .BusMuxInR13(bmr[13]), .BusMuxInR14(bmr[14]), .BusMuxInR15(bmr[15]),
    .BusMuxInHI(bm_hi), .BusMuxInLO(bm_lo), .BusMuxInZhi(bm_zhi), .BusMuxInZlo(bm_zlo),
    .BusMuxInPC(bm_pc), .BusMuxInMDR(bm_mdr), .BusMuxInInport(bm_inport), .BusMuxInY(bm_y)
  );

  function automatic logic [23:0] out_strobes();
    return {Yout, INPORTout, MDRout, PCout, ZLOout | Zout, ZHIout, LOout, HIout, rout};
  endfunction

  function automatic int exp_sel();
    logic [23:0] v;
    v = out_strobes();
    for (int i = 23; i >= 0; i--) if (v[i]) return i;
    return 31;
  endfunction

  function automatic logic [31:0] exp_bus();
    int s;
    s = exp_sel();
    return (s == 31) ? 32'h0 : m[s];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference update: every loaded register takes its source value, all reads see pre-edge state.
  always @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < 24; i++) m[i] = 32'h0;
      chk_en = 1'b1;
    end else begin
      mb = exp_bus();
      if (IncPC)       ma = mb + 32'd1;
      else if (AND_op) ma = m[23] & mb;
      else             ma = mb;
      nm = m;
      for (int i = 0; i < 16; i++) if (rin[i]) nm[i] = mb;
      if (HIin)     nm[16] = mb;
      if (LOin)     nm[17] = mb;
      if (Zin)      begin nm[18] = 32'h0; nm[19] = ma; end
      if (PCin)     nm[20] = mb;
      if (MDRin)    nm[21] = Read ? Mdatain : mb;
      if (INPORTin) nm[22] = mb;
      if (Yin)      nm[23] = mb;
      m = nm;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("enc", 32'(encoderOut), 32'(exp_sel()));
      chk("bus", busMuxOut, exp_bus());
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), bmr[i], m[i]);
      chk("HI", bm_hi, m[16]);   chk("LO", bm_lo, m[17]);
      chk("Zhi", bm_zhi, m[18]); chk("Zlo", bm_zlo, m[19]);
      chk("PC", bm_pc, m[20]);   chk("MDR", bm_mdr, m[21]);
      chk("INPORT", bm_inport, m[22]); chk("Y", bm_y, m[23]);
    end
  end

  task automatic clr();
    rin = '0; rout = '0;
    {HIin, LOin, PCin, MDRin, INPORTin, Zin, Yin, MARin, IRin, AND_op} = '0;
    {HIout, LOout, ZHIout, ZLOout, Zout, PCout, MDRout, INPORTout, Yout} = '0;
    Read = 1'b0; IncPC = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask

  // Loads a register-file entry through MDR: two cycles.
  task automatic load_r(input int idx, input logic [31:0] val);
    clr(); Mdatain = val; Read = 1'b1; MDRin = 1'b1; tick();
    clr(); MDRout = 1'b1; rin[idx] = 1'b1; tick();
  endtask

  initial begin
    clr();
    Mdatain = 32'h0;
    Resetn = 1'b0;
    #2;

    // Reset
    tick();
    Resetn = 1'b1;
    chk("t1_enc", 32'(encoderOut), 32'd31);
    chk("t1_bus", busMuxOut, 32'h0);
    chk("t1_pc", bm_pc, 32'h0);
    chk("t1_zlo", bm_zlo, 32'h0);

    // Register load through MDR
    clr(); Mdatain = 32'h0000_0012; Read = 1'b1; MDRin = 1'b1; tick();
    clr(); MDRout = 1'b1; rin[1] = 1'b1; tick();
    chk("t2_r1", bmr[1], 32'h0000_0012);
    chk("t2_bus", busMuxOut, 32'h0000_0012);

    // Fetch sequence
    clr(); PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
    chk("t3_zlo", bm_zlo, 32'h1);
    clr(); ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h8891_8000; tick();
    chk("t3_pc", bm_pc, 32'h1);
    chk("t3_mdr", bm_mdr, 32'h8891_8000);
    clr(); MDRout = 1'b1; IRin = 1'b1; tick();
    chk("t3_bus", busMuxOut, 32'h8891_8000);

    // AND
    load_r(2, 32'h0F0F_0F0F);
    load_r(3, 32'h0000_00FF);
    clr(); rout[2] = 1'b1; Yin = 1'b1; tick();
    clr(); rout[3] = 1'b1; AND_op = 1'b1; Zin = 1'b1; tick();
    clr(); ZLOout = 1'b1; rin[0] = 1'b1; tick();
    chk("t4_r0", bmr[0], 32'h0000_000F);
    chk("t4_zhi", bm_zhi, 32'h0);
    clr(); Zout = 1'b1; #1;
    chk("t4_zout_enc", 32'(encoderOut), 32'd19);

    // Priority and wrap
    clr(); rout[5] = 1'b1; rout[9] = 1'b1; #1;
    chk("t5_prio", 32'(encoderOut), 32'd9);
    clr(); Mdatain = 32'hFFFF_FFFF; Read = 1'b1; MDRin = 1'b1; tick();
    clr(); MDRout = 1'b1; PCin = 1'b1; tick();
    clr(); PCout = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
    chk("t5_wrap", bm_zlo, 32'h0);
    clr(); rout[1] = 1'b1; IncPC = 1'b1; AND_op = 1'b1; Zin = 1'b1; tick();
    chk("t5_inc_over_and", bm_zlo, 32'h0000_0013);
    clr(); PCout = 1'b1; PCin = 1'b1; tick();
    chk("t5_pc_self", bm_pc, 32'hFFFF_FFFF);

    // Mid-sequence reset
    clr(); rout[3] = 1'b1; Zin = 1'b1; tick();
    chk("t6_zlo_pre", bm_zlo, 32'h0000_00FF);
    clr(); Resetn = 1'b0; MDRout = 1'b1; rin[4] = 1'b1; tick();
    Resetn = 1'b1;
    clr(); ZLOout = 1'b1; rin[0] = 1'b1; tick();
    chk("t6_r0", bmr[0], 32'h0);
    chk("t6_zlo", bm_zlo, 32'h0);
    chk("t6_r4", bmr[4], 32'h0);

    clr(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
